sd_sector_writer: RTL and testbench

Sector write-back engine for the CPU-side SD interface: the outbound counterpart of the existing HPS-to-CPU sector read path. The CPU fills a private 512-byte sector buffer, supplies an LBA and issues a start strobe. The block then raises `sd_wr` towards hps_io and serves buffer bytes on `sd_buff_din` while the HPS pulls the sector. Busy/done/error status is exposed for the CPU flags register.

---
 rtl/sd_sector_writer.sv | 125 ++++++++++++
 tb/tb_sd_sector_writer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sd_sector_writer.sv
// Sector write-back engine: CPU fills a 512x8 buffer, start hands it to hps_io via sd_wr/sd_ack.
// Latency: sd_wr/busy one cycle after start; buf_q and sd_buff_din one cycle after address.
// Backpressure: start ignored while busy; CPU buffer writes while busy are dropped and flag err.
// Optional REQ-phase ack timeout enabled by defining SDW_TIMEOUT_EN.
module sd_sector_writer #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd16777215
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        buf_we,
  input  logic [8:0]  buf_waddr,
  input  logic [7:0]  buf_wdata,
  input  logic [8:0]  buf_raddr,
  output logic [7:0]  buf_q,
  input  logic [31:0] lba_in,
  input  logic        start,
  input  logic        img_size_nz,
  input  logic        flags_clr,
  output logic [31:0] sd_lba,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [8:0]  sd_buff_addr,
  output logic [7:0]  sd_buff_din,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;

  logic [1:0] state;
  logic [7:0] mem [0:511];
  logic       tmo_hit;

  // Buffer has no reset; writes are blocked for the whole transfer window.
  always_ff @(posedge clk_sys) begin
    if (buf_we && !busy) mem[buf_waddr] <= buf_wdata;
  end

  // Both read ports sample the array before this edge's write lands.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      buf_q       <= 8'd0;
      sd_buff_din <= 8'd0;
    end else begin
      buf_q       <= mem[buf_raddr];
      sd_buff_din <= mem[sd_buff_addr];
    end
  end

`ifdef SDW_TIMEOUT_EN
  logic [23:0] tmo_cnt;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)                tmo_cnt <= 24'd0;
    else if (state == S_REQ)  tmo_cnt <= tmo_cnt + 24'd1;
    else                      tmo_cnt <= 24'd0;
  end

  assign tmo_hit = (state == S_REQ) && (tmo_cnt == TIMEOUT_CYCLES - 24'd1);
`else
  logic [23:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
  assign tmo_hit        = 1'b0;
`endif

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      sd_lba <= 32'd0;
      sd_wr  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      // Clear first so any set below in the same cycle takes priority.
      if (flags_clr) begin
        done <= 1'b0;
        err  <= 1'b0;
      end
      if (buf_we && busy) err <= 1'b1;

      case (state)
        S_IDLE: begin
          if (start) begin
            if (img_size_nz) begin
              sd_lba <= lba_in;
              sd_wr  <= 1'b1;
              busy   <= 1'b1;
              done   <= 1'b0;
              err    <= 1'b0;
              state  <= S_REQ;
            end else begin
              err  <= 1'b1;
              done <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (sd_ack) begin
            sd_wr <= 1'b0;
            state <= S_XFER;
          end else if (tmo_hit) begin
            sd_wr <= 1'b0;
            err   <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_XFER: begin
          if (!sd_ack) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_sector_writer.sv
// Randomized bench for sd_sector_writer against a transaction-level buffer/flag model.
module tb_sd_sector_writer;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        buf_we;
  logic [8:0]  buf_waddr;
  logic [7:0]  buf_wdata;
  logic [8:0]  buf_raddr;
  logic [7:0]  buf_q;
  logic [31:0] lba_in;
  logic        start;
  logic        img_size_nz;
  logic        flags_clr;
  logic [31:0] sd_lba;
  logic        sd_wr;
  logic        sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_din;
  logic        busy;
  logic        done;
  logic        err;

  sd_sector_writer #(.TIMEOUT_CYCLES(24'd100)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
    .buf_raddr(buf_raddr), .buf_q(buf_q),
    .lba_in(lba_in), .start(start), .img_size_nz(img_size_nz), .flags_clr(flags_clr),
    .sd_lba(sd_lba), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_din(sd_buff_din),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk_sys = ~clk_sys;

  // Reference model: buffer image plus sticky flags and the last accepted LBA.
  logic [7:0]  ref_mem [0:511];
  logic        model_done;
  logic        model_err;
  logic [31:0] model_lba;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_sys);
  endtask

  task automatic cpu_write(input logic [8:0] a, input logic [7:0] d);
    buf_we = 1'b1; buf_waddr = a; buf_wdata = d;
    tick();
    buf_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic rd_check(input logic [8:0] a);
    buf_raddr = a;
    tick();
    chk("buf_q", {24'd0, buf_q}, {24'd0, ref_mem[a]});
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_done"}, {31'd0, done}, {31'd0, model_done});
    chk({tag, "_err"},  {31'd0, err},  {31'd0, model_err});
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_wr"},   {31'd0, sd_wr}, 32'd0);
  endtask

  // Full write-back: optional ignored restart in REQ, optional blocked CPU write in XFER.
  task automatic do_transfer(input logic [31:0] lba, input int dly, input bit poke_start,
                             input bit poke_we, input logic [8:0] pa, input logic [7:0] pd);
    lba_in = lba; img_size_nz = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; lba_in = $urandom;
    model_lba = lba; model_done = 1'b0; model_err = 1'b0;
    chk("wr_rise", {31'd0, sd_wr}, 32'd1);
    chk("busy_rise", {31'd0, busy}, 32'd1);
    chk("lba", sd_lba, model_lba);
    if (poke_start) begin
      start = 1'b1; lba_in = 32'hFFFFFFFF;
      tick();
      start = 1'b0;
      chk("lba_hold", sd_lba, model_lba);
      chk("wr_hold", {31'd0, sd_wr}, 32'd1);
    end
    repeat (dly) tick();
    chk("wr_before_ack", {31'd0, sd_wr}, 32'd1);
    sd_ack = 1'b1;
    for (int i = 0; i < 512; i++) begin
      sd_buff_addr = 9'(i);
      if (poke_we && i == 100) begin
        buf_we = 1'b1; buf_waddr = pa; buf_wdata = pd;
        model_err = 1'b1;
      end else begin
        buf_we = 1'b0;
      end
      tick();
      if (i == 0) chk("wr_fall", {31'd0, sd_wr}, 32'd0);
      chk("hps_byte", {24'd0, sd_buff_din}, {24'd0, ref_mem[i]});
    end
    buf_we = 1'b0;
    chk("busy_xfer", {31'd0, busy}, 32'd1);
    sd_ack = 1'b0;
    tick();
    model_done = 1'b1;
    check_flags("xfer_end");
    if (poke_we) rd_check(pa);
  endtask

  initial begin
    int cnt;
    reset = 1'b1; buf_we = 1'b0; buf_waddr = '0; buf_wdata = '0; buf_raddr = '0;
    lba_in = '0; start = 1'b0; img_size_nz = 1'b0; flags_clr = 1'b0;
    sd_ack = 1'b0; sd_buff_addr = '0;
    model_done = 1'b0; model_err = 1'b0; model_lba = '0;
    repeat (2) tick();
    chk("rst_lba", sd_lba, 32'd0);
    chk("rst_din", {24'd0, sd_buff_din}, 32'd0);
    chk("rst_q", {24'd0, buf_q}, 32'd0);
    check_flags("rst");
    reset = 1'b0;
    tick();

    for (int i = 0; i < 512; i++) cpu_write(9'(i), 8'(i));
    for (int i = 0; i < 4; i++) rd_check(9'($urandom_range(0, 511)));

    // Directed: LBA 0x1234, ack after 10 cycles, ignored restart during REQ.
    do_transfer(32'h00001234, 10, 1'b1, 1'b0, 9'd0, 8'd0);
    chk("lba_final", sd_lba, 32'h00001234);

    // Empty image: immediate error, no request.
    img_size_nz = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    model_done = 1'b1; model_err = 1'b1;
    check_flags("noimg");
    flags_clr = 1'b1;
    tick();
    flags_clr = 1'b0;
    model_done = 1'b0; model_err = 1'b0;
    check_flags("clr");
    // Set and clear in the same cycle: set wins.
    flags_clr = 1'b1; start = 1'b1;
    tick();
    flags_clr = 1'b0; start = 1'b0;
    model_done = 1'b1; model_err = 1'b1;
    check_flags("clr_vs_set");

    // Stray ack in IDLE changes nothing.
    sd_ack = 1'b1;
    repeat (2) tick();
    sd_ack = 1'b0;
    tick();
    check_flags("idle_ack");

    // Blocked CPU write at addr 5 during XFER.
    do_transfer(32'h00001234, 3, 1'b0, 1'b1, 9'd5, 8'hAA);

    // Randomized transfers with random buffer updates.
    for (int it = 0; it < 6; it++) begin
      repeat ($urandom_range(8, 40)) cpu_write(9'($urandom_range(0, 511)), 8'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        flags_clr = 1'b1;
        tick();
        flags_clr = 1'b0;
        model_done = 1'b0; model_err = 1'b0;
        check_flags("rand_clr");
      end
      do_transfer($urandom, $urandom_range(0, 20), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)), 8'($urandom));
    end

    // Reset mid-XFER: everything drops at once, no completion.
    img_size_nz = 1'b1; lba_in = 32'hCAFE0001; start = 1'b1;
    tick();
    start = 1'b0; sd_ack = 1'b1;
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    chk("rstx_lba", sd_lba, 32'd0);
    model_done = 1'b0; model_err = 1'b0;
    check_flags("rstx");
    sd_ack = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    do_transfer(32'h00ABCDEF, 5, 1'b0, 1'b0, 9'd0, 8'd0);

`ifdef SDW_TIMEOUT_EN
    img_size_nz = 1'b1; lba_in = 32'h55; start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0;
    while (sd_wr && cnt < 200) begin
      tick();
      cnt++;
    end
    chk("tmo_cycles", cnt, 32'd100);
    model_done = 1'b1; model_err = 1'b1;
    check_flags("tmo");
    flags_clr = 1'b1;
    tick();
    flags_clr = 1'b0;
    model_done = 1'b0; model_err = 1'b0;
    check_flags("tmo_clr");
`else
    img_size_nz = 1'b1; lba_in = 32'h55; start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0;
    repeat (300) begin
      tick();
      cnt += sd_wr ? 1 : 0;
    end
    chk("no_tmo_wr", cnt, 32'd300);
    chk("no_tmo_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_done = 1'b0; model_err = 1'b0;
    check_flags("no_tmo_rst");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
